// File: rtl/mac_sequencer.sv
// Sequences the multiply-accumulate of snapshotted weight and data words,
// emitting one dot product per vector over a valid/ready handshake.
module mac_sequencer #(
   parameter int ACC_W  = 18,
   parameter int SIGNED = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      weights,
   input  logic [127:0]     data,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [ACC_W-1:0] result_data,
   output logic [1:0]       result_idx,
   output logic             done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]       state_r;
   logic [31:0]      w_snap_r;
   logic [127:0]     d_snap_r;
   logic [1:0]       v_r;
   logic [1:0]       e_r;
   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] result_data_r;
   logic [1:0]       result_idx_r;
   logic             result_valid_r;
   logic             busy_r;
   logic             done_r;
   logic [ACC_W-1:0] term_s;
   logic [ACC_W-1:0] sum_s;

   // One 8x8 product extended to the accumulator width.
   function automatic logic [ACC_W-1:0] mac_term(input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sp;
      logic [15:0]        up;
      sp = $signed(a) * $signed(b);
      up = a * b;
      if (SIGNED != 0) begin
         mac_term = {{(ACC_W-16){sp[15]}}, sp};
      end else begin
         mac_term = {{(ACC_W-16){1'b0}}, up};
      end
   endfunction

   // Current element product and running sum.
   always_comb begin
      term_s = mac_term(w_snap_r[{e_r, 3'b000} +: 8], d_snap_r[{v_r, e_r, 3'b000} +: 8]);
      sum_s  = acc_r + term_s;
   end

   // Sequencer state, operand snapshot and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         w_snap_r       <= 32'd0;
         d_snap_r       <= 128'd0;
         v_r            <= 2'd0;
         e_r            <= 2'd0;
         acc_r          <= {ACC_W{1'b0}};
         result_data_r  <= {ACC_W{1'b0}};
         result_idx_r   <= 2'd0;
         result_valid_r <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
      end else if (abort && (state_r != ST_IDLE)) begin
         state_r        <= ST_IDLE;
         result_valid_r <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start && !abort) begin
                  w_snap_r <= weights;
                  d_snap_r <= data;
                  v_r      <= 2'd0;
                  e_r      <= 2'd0;
                  acc_r    <= {ACC_W{1'b0}};
                  busy_r   <= 1'b1;
                  state_r  <= ST_MAC;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_MAC: begin
               acc_r <= sum_s;
               e_r   <= e_r + 2'd1;
               if (e_r == 2'd3) begin
                  result_data_r  <= sum_s;
                  result_idx_r   <= v_r;
                  result_valid_r <= 1'b1;
                  state_r        <= ST_OUT;
               end else begin
                  state_r <= ST_MAC;
               end
            end
            ST_OUT: begin
               if (result_ready) begin
                  result_valid_r <= 1'b0;
                  if (v_r == 2'd3) begin
                     done_r  <= 1'b1;
                     state_r <= ST_DONE;
                  end else begin
                     v_r     <= v_r + 2'd1;
                     e_r     <= 2'd0;
                     acc_r   <= {ACC_W{1'b0}};
                     state_r <= ST_MAC;
                  end
               end else begin
                  state_r <= ST_OUT;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               result_valid_r <= 1'b0;
               busy_r         <= 1'b0;
               done_r         <= 1'b0;
               state_r        <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_r;
   assign result_valid = result_valid_r;
   assign result_data  = result_data_r;
   assign result_idx   = result_idx_r;
   assign done         = done_r;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench: a signed and an unsigned instance driven in lockstep,
// checked against a table of known results and an arithmetic reference model.
module tb_mac_sequencer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [31:0]  weights = 32'd0;
   logic [127:0] data = 128'd0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         result_ready = 1'b0;

   logic         busy_s, valid_s, done_s;
   logic [17:0]  data_s;
   logic [1:0]   idx_s;
   logic         busy_u, valid_u, done_u;
   logic [17:0]  data_u;
   logic [1:0]   idx_u;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_sequencer #(.ACC_W(18), .SIGNED(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .weights(weights), .data(data),
      .start(start), .abort(abort), .busy(busy_s), .result_valid(valid_s),
      .result_ready(result_ready), .result_data(data_s), .result_idx(idx_s),
      .done(done_s));

   mac_sequencer #(.ACC_W(18), .SIGNED(0)) dut_u (
      .clk(clk), .rst_n(rst_n), .weights(weights), .data(data),
      .start(start), .abort(abort), .busy(busy_u), .result_valid(valid_u),
      .result_ready(result_ready), .result_data(data_u), .result_idx(idx_u),
      .done(done_u));

   typedef struct {
      logic [31:0]        w;
      logic [127:0]       d;
      logic [3:0][17:0]   es;
      logic [3:0][17:0]   eu;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Dot product of vector v with the weights, computed with plain integers.
   function automatic logic [17:0] model(input logic [31:0] w, input logic [127:0] d,
                                         input int v, input bit sgn);
      int sum;
      sum = 0;
      for (int e = 0; e < 4; e++) begin
         logic [7:0] a;
         logic [7:0] b;
         a = w[8*e +: 8];
         b = d[32*v + 8*e +: 8];
         if (sgn) sum += int'(byte'(a)) * int'(byte'(b));
         else     sum += int'(a) * int'(b);
      end
      return sum[17:0];
   endfunction

   task automatic chk_result(input int v, input logic [17:0] es, input logic [17:0] eu);
      chk("valid", 32'({valid_s, valid_u}), 32'd3);
      chk("data_signed", 32'(data_s), 32'(es));
      chk("data_unsigned", 32'(data_u), 32'(eu));
      chk("idx", 32'({idx_s, idx_u}), 32'({v[1:0], v[1:0]}));
   endtask

   task automatic wait_valid(output int cnt, input bit pulse);
      cnt = 0;
      while (!(valid_s && valid_u) && cnt < 20) begin
         start = pulse && (cnt == 1);
         @(posedge clk); #1;
         cnt++;
      end
      start = 1'b0;
   endtask

   task automatic run_seq(input logic [31:0] w, input logic [127:0] d,
                          input logic [3:0][17:0] es, input logic [3:0][17:0] eu,
                          input int stall_v, input bit pulse);
      int cnt;
      weights = w;
      data    = d;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      weights = $urandom;
      data    = {$urandom, $urandom, $urandom, $urandom};
      chk("busy_after_start", 32'({busy_s, busy_u}), 32'd3);
      for (int v = 0; v < 4; v++) begin
         wait_valid(cnt, pulse);
         chk("latency", 32'(cnt), 32'd4);
         chk_result(v, es[v], eu[v]);
         if (v == stall_v) begin
            for (int s = 0; s < 5; s++) begin
               start = pulse && (s == 2);
               @(posedge clk); #1;
               chk_result(v, es[v], eu[v]);
            end
            start = 1'b0;
         end
         result_ready = 1'b1;
         @(posedge clk); #1;
         result_ready = 1'b0;
         chk("valid_drop", 32'({valid_s, valid_u}), 32'd0);
      end
      chk("done_pulse", 32'({done_s, done_u}), 32'd3);
      chk("busy_in_done", 32'({busy_s, busy_u}), 32'd3);
      @(posedge clk); #1;
      chk("done_clear", 32'({done_s, done_u}), 32'd0);
      chk("busy_clear", 32'({busy_s, busy_u}), 32'd0);
   endtask

   initial begin
      int cnt;
      int seen;
      logic [31:0]      rw;
      logic [127:0]     rd;
      logic [3:0][17:0] es;
      logic [3:0][17:0] eu;

      vecs[0] = '{32'h01010101, 128'h100F0E0D_0C0B0A09_08070605_04030201,
                  {18'd58, 18'd42, 18'd26, 18'd10}, {18'd58, 18'd42, 18'd26, 18'd10}};
      vecs[1] = '{32'h80808080, {16{8'h80}},
                  {4{18'h10000}}, {4{18'h10000}}};
      vecs[2] = '{32'hFFFFFFFF, 128'h100F0E0D_0C0B0A09_08070605_04030201,
                  {18'h3FFC6, 18'h3FFD6, 18'h3FFE6, 18'h3FFF6},
                  {18'd14790, 18'd10710, 18'd6630, 18'd2550}};
      vecs[3] = '{32'hFFFFFFFF, {16{8'hFF}},
                  {4{18'd4}}, {4{18'h3F804}}};

      #2 rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("reset_outputs", 32'({busy_s, valid_s, done_s, idx_s, busy_u, valid_u, done_u, idx_u}), 32'd0);
      chk("reset_data", 32'({data_s, data_u[13:0]}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) begin
         run_seq(vecs[i].w, vecs[i].d, vecs[i].es, vecs[i].eu, (i == 0) ? 1 : 4, (i == 0));
      end

      for (int r = 0; r < 6; r++) begin
         rw = $urandom;
         rd = {$urandom, $urandom, $urandom, $urandom};
         for (int v = 0; v < 4; v++) begin
            es[v] = model(rw, rd, v, 1'b1);
            eu[v] = model(rw, rd, v, 1'b0);
         end
         run_seq(rw, rd, es, eu, r % 4, (r % 2) == 1);
      end

      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle", 32'({busy_s, busy_u}), 32'd0);

      weights = vecs[0].w;
      data    = vecs[0].d;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int v = 0; v < 2; v++) begin
         wait_valid(cnt, 1'b0);
         chk("abort_pre_latency", 32'(cnt), 32'd4);
         result_ready = 1'b1;
         @(posedge clk); #1;
         result_ready = 1'b0;
      end
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", 32'({busy_s, busy_u}), 32'd0);
      seen = 0;
      result_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (valid_s || valid_u || done_s || done_u || busy_s || busy_u) seen++;
         @(posedge clk); #1;
      end
      result_ready = 1'b0;
      chk("abort_quiet", 32'(seen), 32'd0);
      run_seq(vecs[0].w, vecs[0].d, vecs[0].es, vecs[0].eu, 4, 1'b0);

      weights = vecs[3].w;
      data    = vecs[3].d;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_valid(cnt, 1'b0);
      chk("rst_pre_valid", 32'({valid_s, valid_u}), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_ctl", 32'({busy_s, valid_s, busy_u, valid_u}), 32'd0);
      chk("rst_async_data", 32'({data_s, data_u[13:0]}), 32'd0);
      @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (done_s || done_u || busy_s || busy_u || valid_s || valid_u) seen++;
      end
      chk("rst_release_idle", 32'(seen), 32'd0);
      run_seq(vecs[2].w, vecs[2].d, vecs[2].es, vecs[2].eu, 2, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
